wb_host_arbiter: RTL and testbench
==================================

Name: wb_host_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter in front of the user-project register target.
- Master 0 is the Caravel management Wishbone host; master 1 is an LA-driven test master.
- Round-robin arbitration; grant is held for the whole cycle (cyc lock).
- A per-transfer timeout watchdog terminates stalled transfers with err, counts them, and pulses an interrupt.

Parameters:
- TIMEOUT_CYCLES, 16: cycles the strobe may wait for s_ack_i before the arbiter aborts; legal range 2..255.
- CNT_W, 8: width of the saturating timeout counter.

Ports:
- wb_clk_i  in  1  Wishbone clock, the single clock of the block.
- wb_rst_ni  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_ack_o, m0_err_o  out  1 each  master 0 termination.
- m0_dat_o  out  32  master 0 read data.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
- s_sel_o  out  4  slave byte selects.
- s_adr_o, s_dat_o  out  32 each  slave address and write data.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  32  slave read data.
- owner_o  out  2  bit0 = m0 granted, bit1 = m1 granted; never both set.
- timeout_irq_o  out  1  one-cycle pulse per timeout.
- timeout_cnt_o  out  CNT_W  saturating count of timeouts.

Behaviour:
- Reset (async assert, sync deassert in the system): state=IDLE, last_grant=m1 (so m0 wins the first tie), wait counter=0, timeout_cnt_o=0.
- All outputs are 0 during reset and in IDLE.
- States:
  - IDLE: s_cyc_o = 0. A request is cyc&stb. At the clock edge:
    - only m0 requests -> BUSY, owner m0.
    - only m1 requests -> BUSY, owner m1.
    - both request -> grant the master that is not last_grant; last_grant updates to the winner.
    - Arbitration latency is exactly 1 cycle: a request seen at edge N drives the slave from cycle N+1.
  - BUSY: all s_* outputs are a combinational mux of the owner's inputs.
    - owner ack_o = s_ack_i & s_stb_o; the non-owner's ack and err stay 0.
    - s_dat_i is broadcast to both dat_o.
    - The grant stays while owner cyc=1, including multiple stb/ack phases, even if the other master is requesting.
    - When owner cyc=0 at an edge -> IDLE. s_cyc_o drops in the same cycle because it is combinational from the owner.
    - Re-arbitration then takes 1 cycle in IDLE; there is no back-to-back regrant.
  - ERR: s_cyc_o = s_stb_o = 0. The owner's err_o=1 for exactly this one cycle and timeout_irq_o=1. Next state IDLE.
- Wait counter:
  - Cleared on entry to BUSY and on each cycle where s_ack_i=1.
  - Increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - Holds while the owner's stb=0.
  - When it equals TIMEOUT_CYCLES-1 and s_ack_i=0 -> ERR.
  - If s_ack_i=1 on that same cycle, ack wins: no timeout.
- timeout_cnt_o increments on entry to ERR and saturates at all-ones.
- A master dropping cyc mid-wait aborts cleanly: -> IDLE, no err.
- Reset asserted mid-transfer: outputs clear immediately (async), the counter clears, and the grant is lost.
- Both masters' err/ack are never asserted simultaneously; owner_o is one-hot or zero.

Test Plan:
- m0 single write, adr=0x3000_0000, dat=0xBEEF0000, slave acks after 2 wait cycles -> s_cyc_o rises 1 cycle after m0 request; m0_ack_o pulses 1 cycle; m1_ack_o=0; owner_o=01 then 00.
- m0 and m1 request in the same cycle, repeated 4 times with single-cycle acks -> grants m0, m1, m0, m1; each has a 1-cycle IDLE gap.
- m0 holds cyc for 3 stb/ack beats while m1 requests from beat 1 -> m1 is not granted until the cycle after m0 drops cyc; s_adr_o never shows m1's address during m0's cycle.
- Slave never acks, TIMEOUT_CYCLES=16 -> owner err_o=1 exactly 16 cycles after the stb was first driven; timeout_irq_o pulses once; timeout_cnt_o=1; next request is served normally.
- 300 forced timeouts with CNT_W=8 -> timeout_cnt_o saturates at 255.
- wb_rst_ni pulled low mid-wait with m1 owner -> all outputs 0 asynchronously; after release, a tie grants m0 first.

Source files
------------

// File: rtl/wb_host_arbiter.sv
// wb_host_arbiter: round-robin 2-master Wishbone classic arbiter with cyc lock
// and a per-transfer timeout watchdog that terminates stalls with err.
module wb_host_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [31:0]      m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [31:0]      m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [31:0]      m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [31:0]      m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    input  logic             s_ack_i,
    input  logic [31:0]      s_dat_i,
    output logic [1:0]       owner_o,
    output logic             timeout_irq_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d, last_q, last_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             req0, req1, o_cyc, o_stb, busy, err;

    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign o_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    assign o_stb = owner_q ? m1_stb_i : m0_stb_i;
    assign busy  = state_q == BUSY;
    assign err   = state_q == ERR;

    // Slave side is a pure mux of the owner so cyc drops in the cycle the owner drops it
    assign s_cyc_o = busy & o_cyc;
    assign s_stb_o = s_cyc_o & o_stb;
    assign s_we_o  = busy & (owner_q ? m1_we_i : m0_we_i);
    assign s_sel_o = busy ? (owner_q ? m1_sel_i : m0_sel_i) : 4'h0;
    assign s_adr_o = busy ? (owner_q ? m1_adr_i : m0_adr_i) : 32'h0;
    assign s_dat_o = busy ? (owner_q ? m1_dat_i : m0_dat_i) : 32'h0;

    assign m0_ack_o      = ~owner_q & s_stb_o & s_ack_i;
    assign m1_ack_o      =  owner_q & s_stb_o & s_ack_i;
    assign m0_err_o      = err & ~owner_q;
    assign m1_err_o      = err &  owner_q;
    assign m0_dat_o      = busy ? s_dat_i : 32'h0;
    assign m1_dat_o      = busy ? s_dat_i : 32'h0;
    assign owner_o       = state_q == IDLE ? 2'b00 : {owner_q, ~owner_q};
    assign timeout_irq_o = err;
    assign timeout_cnt_o = tcnt_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wait_d  = wait_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d = BUSY;
                owner_d = (req0 & req1) ? ~last_q : req1;
                last_d  = owner_d;
                wait_d  = 8'd0;
            end
            BUSY: if (!o_cyc) state_d = IDLE;
            else if (s_ack_i) wait_d = 8'd0;
            else if (s_stb_o) begin
                // Ack on the final wait cycle wins, so the timeout only fires without it
                if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                    tcnt_d  = &tcnt_q ? tcnt_q : tcnt_q + CNT_W'(1);
                end else wait_d = wait_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wait_q  <= 8'd0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            tcnt_q  <= tcnt_d;
        end
    end
endmodule

// File: tb/tb_wb_host_arbiter.sv
// tb_wb_host_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_wb_host_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cyc = '0, stb = '0, we = '0;
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] wd [2];
    logic        s_ack = 1'b0;
    logic [31:0] s_dat = '0;

    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [1:0]  owner_o;
    logic        timeout_irq_o;
    logic [7:0]  timeout_cnt_o;

    int errors = 0, checks = 0;
    int own, last, waited, tos;
    bit erring;

    always #5 clk = ~clk;

    wb_host_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wd[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wd[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .owner_o(owner_o), .timeout_irq_o(timeout_irq_o), .timeout_cnt_o(timeout_cnt_o)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; waited = 0; tos = 0; erring = 0;
    endtask

    // Expected outputs follow directly from who holds the grant and the live inputs
    task automatic compare_all();
        bit busy;
        int o;
        logic ec, es;
        busy = own >= 0 && !erring;
        o = own < 0 ? 0 : own;
        ec = busy && cyc[o];
        es = ec && stb[o];
        chk("s_cyc_o", s_cyc_o, ec);
        chk("s_stb_o", s_stb_o, es);
        chk("s_we_o", s_we_o, busy && we[o]);
        chk("s_sel_o", s_sel_o, busy ? sel[o] : 4'h0);
        chk("s_adr_o", s_adr_o, busy ? adr[o] : 32'h0);
        chk("s_dat_o", s_dat_o, busy ? wd[o] : 32'h0);
        chk("m0_ack_o", m0_ack_o, busy && own == 0 && es && s_ack);
        chk("m1_ack_o", m1_ack_o, busy && own == 1 && es && s_ack);
        chk("m0_err_o", m0_err_o, erring && own == 0);
        chk("m1_err_o", m1_err_o, erring && own == 1);
        chk("m0_dat_o", m0_dat_o, busy ? s_dat : 32'h0);
        chk("m1_dat_o", m1_dat_o, busy ? s_dat : 32'h0);
        chk("owner_o", owner_o, own < 0 ? 0 : (1 << own));
        chk("timeout_irq_o", timeout_irq_o, erring);
        chk("timeout_cnt_o", timeout_cnt_o, tos > 255 ? 255 : tos);
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        bit r0, r1;
        @(posedge clk);
        #1;
        r0 = cyc[0] && stb[0];
        r1 = cyc[1] && stb[1];
        if (!rst_n) model_reset();
        else if (erring) begin erring = 0; own = -1; end
        else if (own < 0) begin
            if (r0 || r1) begin
                own = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
                last = own;
                waited = 0;
            end
        end
        else if (!cyc[own]) own = -1;
        else if (s_ack) waited = 0;
        else if (stb[own]) begin
            if (waited == TO - 1) begin erring = 1; tos++; end
            else waited++;
        end
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_inputs();
        cyc = '0; stb = '0; we = '0; s_ack = 0; s_dat = '0;
        for (int i = 0; i < 2; i++) begin sel[i] = '0; adr[i] = '0; wd[i] = '0; end
    endtask

    task automatic reset_dut();
        rst_n = 0;
        clear_inputs();
        model_reset();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ackp [4] = '{0, 25, 50, 90};
        int k, nerr;
        clear_inputs();
        model_reset();
        reset_dut();
        settle();
        chk("rst_owner", owner_o, 2'b00);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_cnt", timeout_cnt_o, 0);
        tick();

        // m0 single write, slave acks after two wait cycles
        reset_dut();
        cyc[0] = 1; stb[0] = 1; we[0] = 1; sel[0] = 4'hF;
        adr[0] = 32'h3000_0000; wd[0] = 32'hBEEF_0000;
        settle(); chk("wr_req_cyc", s_cyc_o, 0); tick();
        settle(); chk("wr_cyc", s_cyc_o, 1); chk("wr_owner", owner_o, 2'b01);
        chk("wr_adr", s_adr_o, 32'h3000_0000); chk("wr_dat", s_dat_o, 32'hBEEF_0000); tick();
        step();
        s_ack = 1;
        settle(); chk("wr_ack0", m0_ack_o, 1); chk("wr_ack1", m1_ack_o, 0); tick();
        s_ack = 0; cyc[0] = 0; stb[0] = 0;
        settle(); chk("wr_ack_pulse", m0_ack_o, 0); tick();
        settle(); chk("wr_owner_end", owner_o, 2'b00); tick();

        // simultaneous requests alternate m0, m1, m0, m1 with an idle gap
        reset_dut();
        adr[0] = 32'hA0; adr[1] = 32'hA1;
        for (int r = 0; r < 4; r++) begin
            cyc = 2'b11; stb = 2'b11; s_ack = 0;
            settle(); chk("tie_gap", owner_o, 2'b00); tick();
            s_ack = 1;
            settle(); chk("tie_owner", owner_o, (r % 2) ? 2'b10 : 2'b01);
            chk("tie_adr", s_adr_o, (r % 2) ? 32'hA1 : 32'hA0); tick();
            cyc[r % 2] = 0; stb[r % 2] = 0; s_ack = 0;
            step();
        end

        // cyc lock: m0 keeps the slave for 3 beats while m1 waits
        reset_dut();
        adr[0] = 32'h3000_0010; adr[1] = 32'h3000_0020;
        cyc[0] = 1; stb[0] = 1;
        step();
        for (int b = 0; b < 3; b++) begin
            if (b == 1) begin cyc[1] = 1; stb[1] = 1; end
            stb[0] = 1; s_ack = 1;
            settle(); chk("lock_owner", owner_o, 2'b01); chk("lock_adr", s_adr_o, 32'h3000_0010); tick();
            stb[0] = 0; s_ack = 0;
            settle(); chk("lock_idle_adr", s_adr_o, 32'h3000_0010); tick();
        end
        cyc[0] = 0;
        settle(); chk("lock_drop_cyc", s_cyc_o, 0); chk("lock_drop_owner", owner_o, 2'b01); tick();
        settle(); chk("lock_gap", owner_o, 2'b00); tick();
        settle(); chk("lock_m1_owner", owner_o, 2'b10); chk("lock_m1_adr", s_adr_o, 32'h3000_0020); tick();

        // slave never acks: err exactly TO cycles after stb first reaches the slave
        reset_dut();
        cyc[0] = 1; stb[0] = 1;
        step();
        k = 40;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (m0_err_o) begin
                k = c;
                chk("to_irq", timeout_irq_o, 1);
                chk("to_m1_err", m1_err_o, 0);
                tick();
                break;
            end
            tick();
        end
        chk("to_latency", k, 16);
        s_ack = 1;
        settle(); chk("to_cnt", timeout_cnt_o, 1); chk("to_irq_once", timeout_irq_o, 0); tick();
        settle(); chk("to_next_ack", m0_ack_o, 1); tick();
        clear_inputs();
        step();

        // 300 back-to-back timeouts saturate the counter
        reset_dut();
        cyc[0] = 1; stb[0] = 1;
        nerr = 0;
        for (int c = 0; c < 300 * 18 + 50 && nerr < 300; c++) begin
            settle();
            nerr += int'(m0_err_o);
            tick();
        end
        chk("sat_errs", nerr, 300);
        clear_inputs();
        settle(); chk("sat_cnt", timeout_cnt_o, 8'hFF); tick();

        // async reset mid-wait with m1 owning the slave
        reset_dut();
        cyc[1] = 1; stb[1] = 1; adr[1] = 32'h3000_0040; s_dat = 32'h1234_5678;
        step(); step(); step();
        #3 rst_n = 0;
        model_reset();
        #1;
        chk("ar_cyc", s_cyc_o, 0); chk("ar_stb", s_stb_o, 0); chk("ar_adr", s_adr_o, 0);
        chk("ar_owner", owner_o, 0); chk("ar_dat", m1_dat_o, 0); chk("ar_cnt", timeout_cnt_o, 0);
        step();
        rst_n = 1;
        cyc = 2'b11; stb = 2'b11;
        step();
        settle(); chk("ar_tie_m0", owner_o, 2'b01); tick();

        // randomized traffic across slave responsiveness levels
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc[i]) begin if ($urandom_range(31) == 0) cyc[i] = 0; end
                else if ($urandom_range(3) == 0) cyc[i] = 1;
                stb[i] = cyc[i] && ($urandom_range(3) != 0);
                we[i] = 1'($urandom); sel[i] = 4'($urandom);
                adr[i] = $urandom; wd[i] = $urandom;
            end
            s_ack = $urandom_range(99) < ackp[c / 750];
            s_dat = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
